qsys_serial_initiator: RTL



---
 rtl/qsys_serial_initiator_if.sv | 29 ++
 rtl/qsys_serial_initiator.sv | 128 ++++++++++++
 2 files changed

// File: rtl/qsys_serial_initiator_if.sv
// Avalon-MM slave window plus the 4-wire serial link of the initiator.
// The slave modport is the initiator's own view of these signals.
interface qsys_serial_initiator_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] avs_S1_address;
    logic              avs_S1_read;
    logic              avs_S1_write;
    logic [31:0]       avs_S1_writedata;
    logic [31:0]       avs_S1_readdata;
    logic              avs_S1_waitrequest;
    logic              sdo;
    logic              sle;
    logic              sdi;
    logic              srdy;
    logic              coe_timeout;

    modport slave (
        input  avs_S1_address, avs_S1_read, avs_S1_write, avs_S1_writedata,
        input  sdi, srdy,
        output avs_S1_readdata, avs_S1_waitrequest, sdo, sle, coe_timeout
    );

    modport master (
        output avs_S1_address, avs_S1_read, avs_S1_write, avs_S1_writedata,
        output sdi, srdy,
        input  avs_S1_readdata, avs_S1_waitrequest, sdo, sle, coe_timeout
    );
endinterface

// File: rtl/qsys_serial_initiator.sv
// Tunnels single-word Avalon-MM accesses to a remote host as a 65-bit request
// frame followed by a 32-bit response frame on the sdo/sdi/sle/srdy link.
//
// state      | meaning
// S_IDLE     | waiting for read/write; latches the request frame
// S_SHIFT    | 65 cycles, sle=1, frame sent MSB first on sdo
// S_WAIT_RDY | waiting for srdy, bounded by TIMEOUT
// S_SKIP     | drops the stale first bit of the response window
// S_RECV     | 32 cycles, sdi shifted in MSB first
// S_DONE     | waitrequest released, readdata valid
module qsys_serial_initiator #(
    parameter int TIMEOUT = 1023,
    parameter int ADDR_W  = 8
) (
    input  logic                   csi_MCLK_clk,
    input  logic                   rsi_MRST_reset,
    qsys_serial_initiator_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_WAIT_RDY,
        S_SKIP,
        S_RECV,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [64:0]     frame_q;
    logic [6:0]      bit_cnt_q;
    logic [TW-1:0]   tmo_cnt_q;
    logic [30:0]     rx_q;
    logic [31:0]     readdata_q;
    logic            coe_q;
    logic            req;
    logic            tmo_fire;
    logic [ADDR_W-1:0] addr;
    logic [64:0]     frame_new;

    assign req  = bus.avs_S1_read | bus.avs_S1_write;
    assign addr = bus.avs_S1_address;
    // write wins when both strobes are high: bit64 and the data field follow write alone
    assign frame_new = {bus.avs_S1_write, 32'(addr),
                        bus.avs_S1_write ? bus.avs_S1_writedata : 32'h0};

    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmo_fire = 1'b0;
        case (state_q)
            S_IDLE:     if (req) state_d = S_SHIFT;
            S_SHIFT:    if (bit_cnt_q == 7'd0) state_d = S_WAIT_RDY;
            S_WAIT_RDY: begin
                if (bus.srdy) begin
                    state_d = S_SKIP;
                end else if (tmo_cnt_q == '0) begin
                    state_d  = S_DONE;
                    tmo_fire = 1'b1;
                end
            end
            S_SKIP:     state_d = S_RECV;
            S_RECV:     if (bit_cnt_q == 7'd0) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            frame_q    <= '0;
            bit_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            rx_q       <= '0;
            readdata_q <= '0;
            coe_q      <= 1'b0;
        end else begin
            coe_q <= tmo_fire;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        frame_q   <= frame_new;
                        bit_cnt_q <= 7'd64;
                    end
                end
                S_SHIFT: begin
                    frame_q <= {frame_q[63:0], 1'b0};
                    if (bit_cnt_q == 7'd0) begin
                        tmo_cnt_q <= TW'(TIMEOUT - 1);
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 7'd1;
                    end
                end
                S_WAIT_RDY: begin
                    if (tmo_fire) begin
                        readdata_q <= 32'hFFFF_FFFF;
                    end else if (!bus.srdy) begin
                        tmo_cnt_q <= tmo_cnt_q - TW'(1);
                    end
                end
                S_SKIP: bit_cnt_q <= 7'd31;
                S_RECV: begin
                    rx_q <= {rx_q[29:0], bus.sdi};
                    if (bit_cnt_q == 7'd0) begin
                        readdata_q <= {rx_q, bus.sdi};
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sle                = (state_q == S_SHIFT);
    assign bus.sdo                = (state_q == S_SHIFT) & frame_q[64];
    assign bus.avs_S1_waitrequest = req & (state_q != S_DONE);
    assign bus.avs_S1_readdata    = readdata_q;
    assign bus.coe_timeout        = coe_q;
endmodule
